// File: rtl/dc_blocker_pkg.sv
// Shared widths and arithmetic helpers for the multi-channel DC blocker.
package dc_blocker_pkg;

  // Working width for the stage-B arithmetic; holds the full product of any
  // sensible DATA_W/COEF_W/FRAC/GUARD combination.
  localparam int unsigned MATH_W = 64;

  typedef logic signed [MATH_W-1:0] wide_t;

  // Width of the per-channel integrator state.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned frac,
                                            input int unsigned guard);
    return data_w + frac + guard;
  endfunction

  // Channel index width, never below one bit.
  function automatic int unsigned chan_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Clamp a signed value to the range of a signed field of the given width.
  function automatic wide_t sat_signed(input wide_t value, input int unsigned width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Arithmetic right shift, rounding toward minus infinity.
  function automatic wide_t asr_trunc(input wide_t value, input int unsigned shift);
    return value >>> shift;
  endfunction

endpackage

// File: rtl/dc_state_ram.sv
// Per-channel integrator state: async read, sync write, sync clear and
// write-to-read forwarding so a same-cycle reader sees the fresh value.
module dc_state_ram
  import dc_blocker_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned ACC_W  = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [CH_W-1:0]         rd_chan,
  output logic signed [ACC_W-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_chan,
  input  logic signed [ACC_W-1:0] wr_data
);

  logic signed [ACC_W-1:0] mem [NUM_CH];

  // Storage update: reset/clear zero every channel and win over a writeback.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_chan] <= wr_data;
    end
  end

  // Read port; forwarding is suppressed while a clear is pending so the
  // reader keeps the pre-clear value.
  always_comb begin
    rd_data = '0;
    if (32'(rd_chan) < NUM_CH) rd_data = mem[rd_chan];
    if (wr_en && !clear && (wr_chan == rd_chan)) rd_data = wr_data;
  end

endmodule

// File: rtl/dc_blocker_mc.sv
// Time-multiplexed DC-removal filter: w = x + alpha*w', y = w - w'.
// Two-stage pipeline sharing one multiplier across all channels.
module dc_blocker_mc
  import dc_blocker_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned FRAC   = 15,
  parameter int unsigned GUARD  = 5,
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = chan_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]          s_chan,
  input  logic [COEF_W-1:0]        alpha,
  input  logic                     bypass,
  input  logic                     clear_state,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]          m_chan,
  output logic                     sat_flag
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, FRAC, GUARD);
  localparam int unsigned PROD_W = ACC_W + COEF_W + 1;

  logic                     advance;
  logic                     accept;
  logic                     in_range;
  logic signed [ACC_W-1:0]  rd_state;
  logic signed [PROD_W-1:0] prod;
  logic                     wr_en;
  logic signed [ACC_W-1:0]  w_new;

  logic                     a_valid;
  logic                     a_bypass;
  logic                     a_in_range;
  logic signed [PROD_W-1:0] a_prod;
  logic signed [DATA_W-1:0] a_data;
  logic [CH_W-1:0]          a_chan;
  logic signed [ACC_W-1:0]  a_state;

  wide_t                    w_sum;
  wide_t                    w_sat;
  wide_t                    d_full;
  wide_t                    d_sat;
  logic                     w_clip;
  logic                     d_clip;
  logic signed [DATA_W-1:0] y;
  logic                     y_sat;

  assign advance  = !m_valid || m_ready;
  assign s_ready  = advance;
  assign accept   = s_valid && advance;
  assign in_range = 32'(s_chan) < NUM_CH;
  assign prod     = PROD_W'($signed({1'b0, alpha})) * PROD_W'(rd_state);
  assign wr_en    = advance && a_valid && a_in_range;

  dc_state_ram #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W),
    .ACC_W (ACC_W)
  ) u_state (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_state),
    .rd_chan(s_chan),
    .rd_data(rd_state),
    .wr_en  (wr_en),
    .wr_chan(a_chan),
    .wr_data(w_new)
  );

  // Stage A: capture the accepted beat together with its product and state read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid    <= 1'b0;
      a_bypass   <= 1'b0;
      a_in_range <= 1'b0;
      a_prod     <= '0;
      a_data     <= '0;
      a_chan     <= '0;
      a_state    <= '0;
    end else if (advance) begin
      a_valid <= accept;
      if (accept) begin
        a_prod     <= prod;
        a_data     <= s_data;
        a_chan     <= s_chan;
        a_state    <= rd_state;
        a_bypass   <= bypass;
        a_in_range <= in_range;
      end
    end
  end

  // Stage B: integrate, differentiate and saturate; state is written even in bypass.
  always_comb begin
    w_sum  = (MATH_W'(a_data) <<< FRAC) + asr_trunc(MATH_W'(a_prod), FRAC);
    w_sat  = sat_signed(w_sum, ACC_W);
    w_clip = (w_sat != w_sum);
    d_full = asr_trunc(w_sat - MATH_W'(a_state), FRAC);
    d_sat  = sat_signed(d_full, DATA_W);
    d_clip = (d_sat != d_full);
    w_new  = ACC_W'(w_sat);
    y      = '0;
    y_sat  = 1'b0;
    if (a_in_range) begin
      if (a_bypass) begin
        y = a_data;
      end else begin
        y     = DATA_W'(d_sat);
        y_sat = w_clip || d_clip;
      end
    end
  end

  // Output register: loads on advance, holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_chan   <= '0;
      sat_flag <= 1'b0;
    end else if (advance) begin
      m_valid <= a_valid;
      if (a_valid) begin
        m_data   <= y;
        m_chan   <= a_chan;
        sat_flag <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_dc_blocker_mc.sv
// Scoreboard bench for dc_blocker_mc: a per-channel reference model predicts
// each accepted beat; outputs are compared in order, also while stalled.
module tb_dc_blocker_mc;

  localparam int unsigned NUM_CH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] s_data = '0;
  logic [1:0]         s_chan = '0;
  logic [15:0]        alpha = 16'd31130;
  logic               bypass = 1'b0;
  logic               clear_state = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic signed [15:0] m_data;
  logic [1:0]         m_chan;
  logic               sat_flag;

  dc_blocker_mc #(
    .DATA_W(16),
    .COEF_W(16),
    .FRAC  (15),
    .GUARD (5),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_chan     (s_chan),
    .alpha      (alpha),
    .bypass     (bypass),
    .clear_state(clear_state),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int ch; bit sat; } exp_t;
  typedef struct { int x; int ch; int y; bit sat; } vec_t;

  exp_t   exp_q[$];
  vec_t   vecs[7];
  longint st[NUM_CH];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     tbl_mode = 0;
  int     tbl_y = 0;
  bit     tbl_sat = 0;
  bit     accepted = 0;
  bit     rand_rdy = 0;
  bit     mono_on = 0;
  int     mono_err = 0;
  int     n_out0 = 0;
  int     last0 = 0;
  bit     have0 = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference: w = x*2^15 + floor(alpha*w'/2^15) clamped to 36 bits,
  // y = floor((w - w')/2^15) clamped to 16 bits.
  function automatic void model_step(input int ch, input int x, input int unsigned a,
                                     input bit byp, output int y, output bit sat);
    longint p, w, d, w_hi, w_lo;
    bit ws, ds;
    w_hi = (longint'(1) <<< 35) - 1;
    w_lo = -w_hi - 1;
    p = (longint'(a) * st[ch]) >>> 15;
    w = longint'(x) * 32768 + p;
    ws = 0;
    if (w > w_hi) begin w = w_hi; ws = 1; end
    else if (w < w_lo) begin w = w_lo; ws = 1; end
    d = (w - st[ch]) >>> 15;
    ds = 0;
    if (d > 32767) begin d = 32767; ds = 1; end
    else if (d < -32768) begin d = -32768; ds = 1; end
    st[ch] = w;
    if (byp) begin y = x; sat = 0; end
    else begin y = int'(d); sat = ws | ds; end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(NUM_CH); i++) st[i] = 0;
  endtask

  // One clock: check/accept at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    int   y;
    int   yv;
    bit   sat;
    @(negedge clk);
    accepted = 0;
    if (!rst) begin
      chk("s_ready_law", s_ready, !(m_valid && !m_ready));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", m_valid, 0);
        end else begin
          e = exp_q[0];
          yv = $signed(m_data);
          chk("m_data", yv, e.y);
          chk("m_chan", m_chan, e.ch);
          chk("sat_flag", sat_flag, e.sat);
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (mono_on && m_chan == 2'd0) begin
              if (have0 && yv > last0) mono_err++;
              last0 = yv;
              have0 = 1;
              n_out0++;
            end
          end
        end
      end
      if (s_valid && s_ready) begin
        model_step(int'(s_chan), int'(s_data), alpha, bypass, y, sat);
        if (tbl_mode) begin y = tbl_y; sat = tbl_sat; end
        e.y = y; e.ch = int'(s_chan); e.sat = sat;
        exp_q.push_back(e);
        accepted = 1;
      end
      if (clear_state) model_clear();
    end
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int ch, input int x);
    s_valid = 1'b1;
    s_chan  = 2'(ch);
    s_data  = 16'(x);
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (accepted) break;
    end
    chk("accept", accepted, 1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    s_valid  = 1'b0;
    rand_rdy = 0;
    m_ready  = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    s_valid = 1'b0;
    clear_state = 1'b1;
    cycle();
    clear_state = 1'b0;
  endtask

  task automatic send_tbl(input int i);
    tbl_mode = 1;
    tbl_y    = vecs[i].y;
    tbl_sat  = vecs[i].sat;
    send(vecs[i].ch, vecs[i].x);
    tbl_mode = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{x: 1000,   ch: 0, y: 1000,   sat: 0};
    vecs[1] = '{x: 1000,   ch: 0, y: 950,    sat: 0};
    vecs[2] = '{x: 1000,   ch: 0, y: 902,    sat: 0};
    vecs[3] = '{x: 32767,  ch: 1, y: 32767,  sat: 0};
    vecs[4] = '{x: -32768, ch: 1, y: -32768, sat: 1};
    vecs[5] = '{x: 1000,   ch: 0, y: 1000,   sat: 0};
    vecs[6] = '{x: -500,   ch: 1, y: -500,   sat: 0};
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_s_ready", s_ready, 1);

    // Step response on ch0 with latency check on the first beat
    alpha   = 16'd31130;
    mono_on = 1;
    send_tbl(0);
    chk("latency_a", m_valid, 0);
    cycle();
    chk("latency_b", m_valid, 1);
    for (int i = 1; i < 3; i++) send_tbl(i);
    for (int i = 3; i < 201; i++) send(0, 1000);
    drain();
    mono_on = 0;
    chk("step_monotonic_errors", mono_err, 0);
    chk("step_out_count", n_out0, 201);
    chk("step_y200_in_range", (last0 >= -1 && last0 <= 0), 1);

    // Round-robin interleave
    pulse_clear();
    for (int i = 0; i < 64; i++) begin
      case (i % 4)
        0: send(0, 1000);
        1: send(1, -1000);
        2: send(2, 0);
        default: send(3, 500);
      endcase
    end
    drain();

    // Same channel back-to-back
    pulse_clear();
    for (int i = 0; i < 32; i++) send(2, 2000);
    drain();

    // Backpressure with random channels, data, alpha and gaps
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      alpha = 16'($urandom_range(20000, 32767));
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 3) == 0) cycle();
    end
    drain();

    // Full-scale alternation
    pulse_clear();
    alpha = 16'd32767;
    send_tbl(3);
    send_tbl(4);
    for (int i = 2; i < 20; i++) send(1, (i % 2) ? -32768 : 32767);
    drain();

    // Clear mid-stream: last beat's writeback coincides with the clear
    alpha = 16'd31130;
    send(1, 700);
    for (int i = 0; i < 4; i++) send(0, 1000);
    pulse_clear();
    send_tbl(5);
    send_tbl(6);
    drain();

    // Bypass, then resume filtering without a step
    bypass = 1'b1;
    send(3, 1234);
    chk("bypass_latency_a", m_valid, 0);
    cycle();
    chk("bypass_latency_b", m_valid, 1);
    send(3, -777);
    send(0, 32767);
    send(0, -32768);
    send(0, 1000);
    drain();
    bypass = 1'b0;
    for (int i = 0; i < 12; i++) send(i % 2 == 0 ? 0 : 3, 1000);
    drain();

    // Reset while beats are in flight and output is stalled
    m_ready = 1'b0;
    send(2, 900);
    send(2, 900);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    exp_q.delete();
    model_clear();
    m_ready = 1'b1;
    tbl_mode = 1;
    tbl_y    = 900;
    tbl_sat  = 0;
    send(2, 900);
    tbl_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
